// File: rtl/twi_video_target.sv
// TWI/I2C target modelling the video encoder register interface.
// Matches a 7-bit device address, accepts a pointer byte followed by
// auto-incrementing burst writes, and serves auto-incrementing burst reads
// from the current pointer. Committed writes are mirrored on a strobe.
//
// Ports:
//   i_clk, i_rst      system clock, synchronous active-high reset
//   i_twi_scl         SCL from the bus (asynchronous)
//   i_twi_sda         SDA from the bus, wired-AND value (asynchronous)
//   o_twi_sda         SDA drive: 0 pulls low, 1 releases
//   o_reg_wr_en       one-clock pulse per committed data byte
//   o_reg_wr_addr     register index of the committed byte
//   o_reg_wr_data     committed byte
//   o_busy            high from the ACKed address until STOP or read NACK
module twi_video_target #(
    parameter logic [6:0]  DEV_ADDR = 7'h76,
    parameter int unsigned NREGS    = 128,
    parameter logic [7:0]  RST_VAL  = 8'h00
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_twi_scl,
    input  logic                     i_twi_sda,
    output logic                     o_twi_sda,
    output logic                     o_reg_wr_en,
    output logic [$clog2(NREGS)-1:0] o_reg_wr_addr,
    output logic [7:0]               o_reg_wr_data,
    output logic                     o_busy
);

    localparam int unsigned PW = $clog2(NREGS);
    localparam int unsigned CW = 3;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;

    state_t         state, state_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic [7:0]     sh, sh_d;
    logic [PW-1:0]  ptr, ptr_d;
    logic           rw, rw_d;
    logic           ack_drv, ack_d;
    logic           sda_q, sda_d;
    logic           busy, busy_d;
    logic           wr_en, wr_en_d;
    logic [PW-1:0]  wr_addr, wr_addr_d;
    logic [7:0]     wr_data, wr_data_d;

    logic [7:0]     regs [NREGS];

    // Two-FF synchroniser plus one history stage; detection uses stages 1/2.
    logic [2:0] scl_s, sda_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_s <= 3'b111;
            sda_s <= 3'b111;
        end else begin
            scl_s <= {scl_s[1:0], i_twi_scl};
            sda_s <= {sda_s[1:0], i_twi_sda};
        end
    end

    logic          scl_rise, scl_fall, start_det, stop_det, sda_bit, byte_done;
    logic [7:0]    byte_c;
    logic [PW-1:0] ptr_inc;

    assign scl_rise  = scl_s[1] & ~scl_s[2];
    assign scl_fall  = ~scl_s[1] & scl_s[2];
    assign start_det = scl_s[1] & scl_s[2] & sda_s[2] & ~sda_s[1];
    assign stop_det  = scl_s[1] & scl_s[2] & ~sda_s[2] & sda_s[1];
    assign sda_bit   = sda_s[1];
    assign byte_c    = {sh[6:0], sda_bit};
    assign byte_done = scl_rise && (cnt == CW'(7));
    assign ptr_inc   = PW'(ptr + PW'(1));

    // Next-state and output logic; bus conditions override bit handling.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        sh_d      = sh;
        ptr_d     = ptr;
        rw_d      = rw;
        ack_d     = ack_drv;
        sda_d     = sda_q;
        busy_d    = busy;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;

        if (stop_det) begin
            state_d = IDLE;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
            ack_d   = 1'b0;
            cnt_d   = '0;
        end else if (start_det) begin
            state_d = ADDR;
            sda_d   = 1'b1;
            ack_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state)
                IDLE, IGNORE: begin
                    sda_d = 1'b1;
                end
                ADDR: begin
                    if (scl_rise) begin
                        sh_d  = byte_c;
                        cnt_d = CW'(cnt + CW'(1));
                    end
                    if (byte_done) begin
                        cnt_d = '0;
                        if (byte_c[7:1] == DEV_ADDR) begin
                            rw_d    = byte_c[0];
                            state_d = ADDR_ACK;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        sh_d  = byte_c;
                        cnt_d = CW'(cnt + CW'(1));
                    end
                    if (byte_done) begin
                        cnt_d   = '0;
                        ptr_d   = byte_c[PW-1:0];
                        state_d = PTR_ACK;
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        sh_d  = byte_c;
                        cnt_d = CW'(cnt + CW'(1));
                    end
                    if (byte_done) begin
                        cnt_d     = '0;
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr;
                        wr_data_d = byte_c;
                        ptr_d     = ptr_inc;
                        state_d   = WR_ACK;
                    end
                end
                // First fall pulls SDA low for the ACK bit, the second ends it.
                ADDR_ACK, PTR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_drv) begin
                            sda_d = 1'b0;
                            ack_d = 1'b1;
                            if (state == ADDR_ACK) begin
                                busy_d = 1'b1;
                            end
                        end else begin
                            sda_d = 1'b1;
                            ack_d = 1'b0;
                            cnt_d = '0;
                            if (state == ADDR_ACK && rw) begin
                                sh_d    = regs[ptr];
                                sda_d   = regs[ptr][7];
                                state_d = RD_DATA;
                            end else if (state == ADDR_ACK) begin
                                state_d = PTR;
                            end else begin
                                state_d = WR_DATA;
                            end
                        end
                    end
                end
                // sh[7] is the bit currently on the bus.
                RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt == CW'(7)) begin
                            sda_d   = 1'b1;
                            cnt_d   = '0;
                            ack_d   = 1'b0;
                            state_d = RD_ACK;
                        end else begin
                            sda_d = sh[6];
                            sh_d  = {sh[6:0], 1'b0};
                            cnt_d = CW'(cnt + CW'(1));
                        end
                    end
                end
                // ack_drv marks a master ACK seen and the next byte preloaded.
                RD_ACK: begin
                    if (scl_rise && !ack_drv) begin
                        if (!sda_bit) begin
                            ptr_d = ptr_inc;
                            sh_d  = regs[ptr_inc];
                            ack_d = 1'b1;
                        end else begin
                            sda_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IGNORE;
                        end
                    end else if (scl_fall && ack_drv) begin
                        sda_d   = sh[7];
                        ack_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = RD_DATA;
                    end
                end
                default: begin
                    state_d = IDLE;
                    sda_d   = 1'b1;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sh      <= '0;
            ptr     <= '0;
            rw      <= 1'b0;
            ack_drv <= 1'b0;
            sda_q   <= 1'b1;
            busy    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            sh      <= sh_d;
            ptr     <= ptr_d;
            rw      <= rw_d;
            ack_drv <= ack_d;
            sda_q   <= sda_d;
            busy    <= busy_d;
            wr_en   <= wr_en_d;
            wr_addr <= wr_addr_d;
            wr_data <= wr_data_d;
        end
    end

    // Register file commits from the registered strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= RST_VAL;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign o_twi_sda     = sda_q;
    assign o_busy        = busy;
    assign o_reg_wr_en   = wr_en;
    assign o_reg_wr_addr = wr_addr;
    assign o_reg_wr_data = wr_data;

endmodule

// File: tb/tb_twi_video_target.sv
// Bit-banged TWI master driving twi_video_target with a register model and
// scoreboard queues for write strobes and read bytes.
module tb_twi_video_target;

    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       dut_sda;
    logic       bus_sda;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mdl [128];
    logic [6:0]  ptr_m;
    logic [14:0] exp_wr [$];
    logic [14:0] got_wr [$];
    logic [7:0]  exp_rd [$];

    assign bus_sda = sda_m & dut_sda;

    always #5 clk = ~clk;

    twi_video_target dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_twi_scl     (scl),
        .i_twi_sda     (bus_sda),
        .o_twi_sda     (dut_sda),
        .o_reg_wr_en   (wr_en),
        .o_reg_wr_addr (wr_addr),
        .o_reg_wr_data (wr_data),
        .o_busy        (busy)
    );

    always @(negedge clk) begin
        if (wr_en) got_wr.push_back({wr_addr, wr_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold();
        repeat (T) @(negedge clk);
    endtask

    task automatic bit_out(input logic b);
        sda_m = b; hold();
        scl = 1'b1; hold();
        scl = 1'b0; hold();
    endtask

    task automatic bit_in(output logic b);
        sda_m = 1'b1; hold();
        scl = 1'b1;
        repeat (T / 2) @(negedge clk);
        b = bus_sda;
        repeat (T / 2) @(negedge clk);
        scl = 1'b0; hold();
    endtask

    task automatic start_cond();
        sda_m = 1'b1; hold();
        scl = 1'b1; hold();
        sda_m = 1'b0; hold();
        scl = 1'b0; hold();
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; hold();
        scl = 1'b1; hold();
        sda_m = 1'b1; hold();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ackb);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(ackb);
    endtask

    task automatic addr(input string tag, input logic [7:0] a, input logic exp_ack);
        logic ack;
        write_byte(a, ack);
        chk(tag, 32'(ack), 32'(exp_ack));
    endtask

    task automatic set_ptr(input string tag, input logic [7:0] p);
        logic ack;
        write_byte(p, ack);
        chk(tag, 32'(ack), 32'd0);
        ptr_m = p[6:0];
    endtask

    task automatic wr(input string tag, input logic [7:0] d);
        logic ack;
        exp_wr.push_back({ptr_m, d});
        mdl[ptr_m] = d;
        ptr_m++;
        write_byte(d, ack);
        chk(tag, 32'(ack), 32'd0);
    endtask

    task automatic rd(input string tag, input logic ackb);
        logic [7:0] d;
        exp_rd.push_back(mdl[ptr_m]);
        read_byte(d, ackb);
        chk(tag, 32'(d), 32'(exp_rd.pop_front()));
        if (!ackb) ptr_m++;
    endtask

    task automatic drain_wr(input string tag);
        chk({tag, "_count"}, 32'(got_wr.size()), 32'(exp_wr.size()));
        while (exp_wr.size() > 0 && got_wr.size() > 0)
            chk({tag, "_strobe"}, 32'(got_wr.pop_front()), 32'(exp_wr.pop_front()));
        exp_wr.delete();
        got_wr.delete();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mdl[i] = 8'h00;
        ptr_m = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sda", 32'(dut_sda), 32'd1);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        hold();

        // Pointer write then two data bytes.
        start_cond();
        addr("t1_addr_ack", 8'hEC, 1'b0);
        chk("t1_busy", 32'(busy), 32'd1);
        set_ptr("t1_ptr_ack", 8'h1C);
        wr("t1_d0_ack", 8'h04);
        wr("t1_d1_ack", 8'h45);
        stop_cond();
        chk("t1_busy_stop", 32'(busy), 32'd0);
        drain_wr("t1");

        // Pointer write, repeated START, burst read ACK then NACK.
        start_cond();
        addr("t2_addr_ack", 8'hEC, 1'b0);
        set_ptr("t2_ptr_ack", 8'h1C);
        start_cond();
        addr("t2_raddr_ack", 8'hED, 1'b0);
        rd("t2_rd0", 1'b0);
        rd("t2_rd1", 1'b1);
        chk("t2_sda_nack", 32'(dut_sda), 32'd1);
        chk("t2_busy_nack", 32'(busy), 32'd0);
        stop_cond();
        drain_wr("t2");

        // Foreign address is ignored until STOP.
        start_cond();
        addr("t3_addr_nack", 8'hA0, 1'b1);
        chk("t3_busy", 32'(busy), 32'd0);
        addr("t3_d0_nack", 8'h00, 1'b1);
        addr("t3_d1_nack", 8'h55, 1'b1);
        chk("t3_sda", 32'(dut_sda), 32'd1);
        stop_cond();
        drain_wr("t3");

        // Write burst wrapping the pointer, then read it back.
        start_cond();
        addr("t4_addr_ack", 8'hEC, 1'b0);
        set_ptr("t4_ptr_ack", 8'h7F);
        wr("t4_d0_ack", 8'hAA);
        wr("t4_d1_ack", 8'hBB);
        stop_cond();
        drain_wr("t4");
        start_cond();
        addr("t4_waddr_ack", 8'hEC, 1'b0);
        set_ptr("t4_rptr_ack", 8'h7F);
        start_cond();
        addr("t4_raddr_ack", 8'hED, 1'b0);
        rd("t4_rd0", 1'b0);
        rd("t4_rd1", 1'b1);
        stop_cond();

        // STOP part way through a data byte discards it.
        start_cond();
        addr("t5_addr_ack", 8'hEC, 1'b0);
        set_ptr("t5_ptr_ack", 8'h1C);
        for (int i = 0; i < 5; i++) bit_out(1'b1);
        stop_cond();
        chk("t5_sda", 32'(dut_sda), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        drain_wr("t5");
        start_cond();
        addr("t5_raddr_ack", 8'hED, 1'b0);
        rd("t5_rd_keep", 1'b1);
        stop_cond();

        // Reset while the target is pulling the address ACK low.
        start_cond();
        for (int i = 7; i >= 0; i--) bit_out(i == 0 ? 1'b0 : ((8'hEC >> i) & 8'h01) != 0);
        chk("t6_ack_low", 32'(dut_sda), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_sda_rst", 32'(dut_sda), 32'd1);
        chk("t6_busy_rst", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 128; i++) mdl[i] = 8'h00;
        ptr_m = '0;
        exp_wr.delete();
        got_wr.delete();
        stop_cond();
        start_cond();
        addr("t6_raddr_ack", 8'hED, 1'b0);
        rd("t6_rd_p0", 1'b0);
        rd("t6_rd_p1", 1'b1);
        stop_cond();
        start_cond();
        addr("t6_waddr_ack", 8'hEC, 1'b0);
        set_ptr("t6_ptr_ack", 8'h1C);
        start_cond();
        addr("t6_raddr2_ack", 8'hED, 1'b0);
        rd("t6_rd_1c", 1'b0);
        rd("t6_rd_1d", 1'b1);
        stop_cond();
        start_cond();
        addr("t6_waddr3_ack", 8'hEC, 1'b0);
        set_ptr("t6_ptr3_ack", 8'h7F);
        start_cond();
        addr("t6_raddr3_ack", 8'hED, 1'b0);
        rd("t6_rd_7f", 1'b0);
        rd("t6_rd_00", 1'b1);
        stop_cond();
        drain_wr("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
